cache_ctrl: RTL and testbench

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_ctrl_if.sv | 26 ++
 rtl/cache_ctrl.sv | 151 +++++++++++++++
 tb/tb_cache_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_if.sv
// CPU request/response and main-memory port bundle for cache_ctrl.
// slave = the cache controller, master = the CPU plus memory environment.
interface cache_ctrl_if;
    logic       cpu_req;
    logic       cpu_wren;
    logic [7:0] cpu_tag;
    logic [7:0] cpu_wdata;
    logic       cpu_ready;
    logic       cpu_done;
    logic       cpu_hit;
    logic [7:0] cpu_rdata;
    logic [7:0] mp_address;
    logic [7:0] mp_data;
    logic       mp_wren;
    logic [7:0] mp_q;

    modport slave (
        input  cpu_req, cpu_wren, cpu_tag, cpu_wdata, mp_q,
        output cpu_ready, cpu_done, cpu_hit, cpu_rdata, mp_address, mp_data, mp_wren
    );

    modport master (
        output cpu_req, cpu_wren, cpu_tag, cpu_wdata, mp_q,
        input  cpu_ready, cpu_done, cpu_hit, cpu_rdata, mp_address, mp_data, mp_wren
    );
endinterface

// File: rtl/cache_ctrl.sv
// 4-line fully associative write-back cache controller with true-LRU replacement.
// CACHE_CTRL_WRITE_ALLOCATE_EN selects write-allocate on write miss (default: write-through no-allocate).
module cache_ctrl (
    input logic         clock,
    input logic         resetn,
    cache_ctrl_if.slave bus
);
`ifdef CACHE_CTRL_WRITE_ALLOCATE_EN
    localparam bit ALLOC = 1'b1;
`else
    localparam bit ALLOC = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, LOOKUP, WRBACK, FETCH, FETCH_WAIT, RESPOND} state_t;
    state_t state, state_nxt;

    logic [3:0][7:0] tag, data;
    logic [3:0]      valid, dirty;
    logic [3:0][1:0] age;

    logic       wren_r, hit_r;
    logic [7:0] tag_r, wdata_r, rdata_r;
    logic [1:0] way_r;

    logic       hit;
    logic [1:0] hit_way, vic_way;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int i = 0; i < 4; i++)
            if (valid[i] && tag[i] == tag_r) begin
                hit     = 1'b1;
                hit_way = 2'(i);
            end
    end

    // Prefer the lowest empty line; only evict the LRU line when all are full.
    always_comb begin
        vic_way = '0;
        if (&valid) begin
            for (int i = 0; i < 4; i++)
                if (age[i] == 2'd3) vic_way = 2'(i);
        end else begin
            for (int i = 3; i >= 0; i--)
                if (!valid[i]) vic_way = 2'(i);
        end
    end

    always_ff @(posedge clock or negedge resetn)
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (bus.cpu_req) state_nxt = LOOKUP;
            LOOKUP: begin
                if (hit)                                    state_nxt = RESPOND;
                else if (wren_r && !ALLOC)                  state_nxt = WRBACK;
                else if (valid[vic_way] && dirty[vic_way])  state_nxt = WRBACK;
                else if (wren_r)                            state_nxt = RESPOND;
                else                                        state_nxt = FETCH;
            end
            WRBACK:     state_nxt = wren_r ? RESPOND : FETCH;
            FETCH:      state_nxt = FETCH_WAIT;
            FETCH_WAIT: state_nxt = RESPOND;
            RESPOND:    state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.cpu_ready  = (state == IDLE);
        bus.cpu_done   = (state == RESPOND);
        bus.cpu_hit    = (state == RESPOND) && hit_r;
        bus.cpu_rdata  = rdata_r;
        bus.mp_address = '0;
        bus.mp_data    = '0;
        bus.mp_wren    = 1'b0;
        case (state)
            WRBACK: begin
                bus.mp_wren = 1'b1;
                // Without allocation, WRBACK doubles as the write-through cycle.
                if (wren_r && !ALLOC) begin
                    bus.mp_address = tag_r;
                    bus.mp_data    = wdata_r;
                end else begin
                    bus.mp_address = tag[way_r];
                    bus.mp_data    = data[way_r];
                end
            end
            FETCH:   bus.mp_address = tag_r;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tag     <= '0;
            data    <= '0;
            valid   <= '0;
            dirty   <= '0;
            for (int i = 0; i < 4; i++) age[i] <= 2'(i);
            wren_r  <= 1'b0;
            hit_r   <= 1'b0;
            tag_r   <= '0;
            wdata_r <= '0;
            rdata_r <= '0;
            way_r   <= '0;
        end else begin
            case (state)
                IDLE: if (bus.cpu_req) begin
                    wren_r  <= bus.cpu_wren;
                    tag_r   <= bus.cpu_tag;
                    wdata_r <= bus.cpu_wdata;
                end
                LOOKUP: begin
                    hit_r <= hit;
                    way_r <= hit ? hit_way : vic_way;
                    if (hit && !wren_r) rdata_r <= data[hit_way];
                    if (hit && wren_r) begin
                        data[hit_way]  <= wdata_r;
                        dirty[hit_way] <= 1'b1;
                    end
                end
                FETCH_WAIT: begin
                    data[way_r]  <= bus.mp_q;
                    tag[way_r]   <= tag_r;
                    valid[way_r] <= 1'b1;
                    dirty[way_r] <= 1'b0;
                    rdata_r      <= bus.mp_q;
                end
                RESPOND: begin
                    if (!hit_r && wren_r && ALLOC) begin
                        data[way_r]  <= wdata_r;
                        tag[way_r]   <= tag_r;
                        valid[way_r] <= 1'b1;
                        dirty[way_r] <= 1'b1;
                    end
                    // A non-allocating write miss leaves the cache, ages included, untouched.
                    if (hit_r || !wren_r || ALLOC)
                        for (int i = 0; i < 4; i++)
                            if (2'(i) == way_r)        age[i] <= 2'd0;
                            else if (age[i] < age[way_r]) age[i] <= age[i] + 2'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: directed scenarios plus random traffic
// checked against a recency-list cache model and a reference memory.
module tb_cache_ctrl;
`ifdef CACHE_CTRL_WRITE_ALLOCATE_EN
    localparam bit ALLOC = 1'b1;
`else
    localparam bit ALLOC = 1'b0;
`endif

    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    cache_ctrl_if bus ();
    cache_ctrl dut (.clock(clock), .resetn(resetn), .bus(bus));

    logic [7:0]  mem    [256];
    logic [7:0]  refmem [256];
    logic [15:0] wlog   [$];

    // Synchronous memory: read data appears one clock after the address.
    always @(posedge clock) begin
        if (bus.mp_wren === 1'b1) begin
            mem[bus.mp_address] <= bus.mp_data;
            wlog.push_back({bus.mp_address, bus.mp_data});
        end
        bus.mp_q <= mem[bus.mp_address];
    end

    int tests = 0;
    int fails = 0;

    logic [7:0] m_tag [4];
    logic [7:0] m_data[4];
    bit         m_val [4];
    bit         m_dirty[4];
    int         lru[$];   // line indices, most recently used first

    int          obs_lat, obs_nwr;
    logic        obs_hit;
    logic [7:0]  obs_rd;
    logic [15:0] obs_wr;

    task automatic chk(input string nm, input logic [15:0] o, input logic [15:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", nm, o, e);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_tag[i] = '0; m_data[i] = '0; m_val[i] = 0; m_dirty[i] = 0;
        end
        lru = {0, 1, 2, 3};
    endfunction

    function automatic void touch(input int w);
        int pos = -1;
        for (int i = 0; i < lru.size(); i++) if (lru[i] == w) pos = i;
        if (pos >= 0) lru.delete(pos);
        lru.push_front(w);
    endfunction

    function automatic int victim();
        for (int i = 0; i < 4; i++) if (!m_val[i]) return i;
        return lru[3];
    endfunction

    task automatic access(input bit wr, input logic [7:0] t, input logic [7:0] wd);
        int h = -1, v, elat = 0, lat;
        bit ehit, ewb = 0, got;
        logic [7:0]  erd = '0;
        logic [15:0] ewr = '0;
        for (int i = 0; i < 4; i++) if (m_val[i] && m_tag[i] == t) h = i;
        ehit = (h >= 0);
        if (ehit) begin
            elat = 2;
            if (wr) begin m_data[h] = wd; m_dirty[h] = 1; end
            else erd = m_data[h];
            touch(h);
        end else if (wr && !ALLOC) begin
            ewb = 1; ewr = {t, wd}; refmem[t] = wd; elat = 3;
        end else begin
            v = victim();
            if (m_val[v] && m_dirty[v]) begin
                ewb = 1; ewr = {m_tag[v], m_data[v]}; refmem[m_tag[v]] = m_data[v];
            end
            if (wr) begin m_data[v] = wd; m_dirty[v] = 1; elat = ewb ? 3 : 2; end
            else begin m_data[v] = refmem[t]; m_dirty[v] = 0; erd = refmem[t]; elat = ewb ? 5 : 4; end
            m_tag[v] = t; m_val[v] = 1; touch(v);
        end

        wlog.delete();
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clock);
            got = (bus.cpu_ready === 1'b1);
        end
        chk("ready_wait", 16'(got), 16'd1);
        bus.cpu_req = 1'b1; bus.cpu_wren = wr; bus.cpu_tag = t; bus.cpu_wdata = wd;
        @(posedge clock);
        #1 bus.cpu_req = 1'b0;
        lat = 0; got = 0;
        while (!got && lat < 20) begin
            @(negedge clock);
            lat++;
            if (bus.cpu_done === 1'b1) got = 1;
            else begin
                // Requests while busy must be ignored.
                bus.cpu_req = 1'($urandom_range(0, 1)); bus.cpu_wren = 1'($urandom_range(0, 1));
                bus.cpu_tag = 8'($urandom); bus.cpu_wdata = 8'($urandom);
            end
        end
        bus.cpu_req = 1'b0;
        obs_lat = lat; obs_hit = bus.cpu_hit; obs_rd = bus.cpu_rdata;
        chk("done_seen", 16'(got), 16'd1);
        chk("latency", 16'(lat), 16'(elat));
        chk("hit", 16'(bus.cpu_hit), 16'(ehit));
        if (!wr) chk("rdata", 16'(bus.cpu_rdata), 16'(erd));
        @(posedge clock);
        #1;
        chk("done_pulse", 16'(bus.cpu_done), 16'd0);
        obs_nwr = wlog.size();
        obs_wr  = (wlog.size() > 0) ? wlog[0] : 16'h0;
        chk("mp_writes", 16'(obs_nwr), 16'(ewb));
        if (ewb) chk("mp_wr_addr_data", obs_wr, ewr);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_ready"}, 16'(bus.cpu_ready), 16'd1);
        chk({nm, "_done"},  16'(bus.cpu_done),  16'd0);
        chk({nm, "_hit"},   16'(bus.cpu_hit),   16'd0);
        chk({nm, "_rdata"}, 16'(bus.cpu_rdata), 16'd0);
        chk({nm, "_maddr"}, 16'(bus.mp_address), 16'd0);
        chk({nm, "_mdata"}, 16'(bus.mp_data),   16'd0);
        chk({nm, "_mwren"}, 16'(bus.mp_wren),   16'd0);
    endtask

    task automatic do_reset();
        @(negedge clock) resetn = 1'b0;
        @(negedge clock) resetn = 1'b1;
        model_reset();
    endtask

    initial begin
        bus.cpu_req = 0; bus.cpu_wren = 0; bus.cpu_tag = 0; bus.cpu_wdata = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h05] = 8'h15;
        for (int i = 0; i < 256; i++) refmem[i] = mem[i];
        model_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        check_reset_outputs("reset");
        resetn = 1'b1;

        // Cold read miss, then repeated read hit.
        access(0, 8'h05, 0);
        chk("r34_lat", 16'(obs_lat), 16'd4);
        chk("r34_rd", 16'(obs_rd), 16'h15);
        chk("r34_hit", 16'(obs_hit), 16'd0);
        access(0, 8'h05, 0);
        chk("r35_lat", 16'(obs_lat), 16'd2);
        chk("r35_hit", 16'(obs_hit), 16'd1);
        chk("r35_nwr", 16'(obs_nwr), 16'd0);

        // Clean LRU eviction keeps the dirty line.
        do_reset();
        for (int t = 1; t <= 4; t++) access(0, 8'(t), 0);
        access(1, 8'h01, 8'hAA);
        chk("r36_wrhit", 16'(obs_hit), 16'd1);
        access(0, 8'h09, 0);
        chk("r36_clean_nwr", 16'(obs_nwr), 16'd0);
        chk("r36_clean_lat", 16'(obs_lat), 16'd4);
        access(0, 8'h01, 0);
        chk("r36_rd_aa", 16'(obs_rd), 16'hAA);

        // Age the dirty line to LRU, then force its write-back.
        access(0, 8'h04, 0);
        access(0, 8'h03, 0);
        access(0, 8'h09, 0);
        access(0, 8'h0A, 0);
        chk("r37_nwr", 16'(obs_nwr), 16'd1);
        chk("r37_wb", obs_wr, 16'h01AA);
        chk("r37_lat", 16'(obs_lat), 16'd5);

        access(1, 8'h30, 8'h77);
        chk("r38_wmiss_hit", 16'(obs_hit), 16'd0);
`ifdef CACHE_CTRL_WRITE_ALLOCATE_EN
        chk("r38_alloc_lat", 16'(obs_lat), 16'd2);
        access(0, 8'h30, 0);
        chk("r38_alloc_rdhit", 16'(obs_hit), 16'd1);
        chk("r38_alloc_rd", 16'(obs_rd), 16'h77);
`else
        chk("r38_wt_lat", 16'(obs_lat), 16'd3);
        chk("r38_wt_wr", obs_wr, 16'h3077);
        access(0, 8'h30, 0);
        chk("r38_wt_rdmiss", 16'(obs_hit), 16'd0);
        chk("r38_wt_rd", 16'(obs_rd), 16'h77);
`endif

        for (int n = 0; n < 200; n++)
            access($urandom_range(0, 2) == 0, 8'($urandom_range(0, 11)), 8'($urandom));

        // Reset during a fill: abandon it, no completion, cache empty afterwards.
        @(negedge clock);
        while (bus.cpu_ready !== 1'b1) @(negedge clock);
        bus.cpu_req = 1'b1; bus.cpu_wren = 1'b0; bus.cpu_tag = 8'hEE; bus.cpu_wdata = 0;
        @(posedge clock);
        #1 bus.cpu_req = 1'b0;
        repeat (3) @(negedge clock);
        resetn = 1'b0;
        #1;
        check_reset_outputs("midfill");
        repeat (2) begin
            @(negedge clock);
            chk("midfill_nodone", 16'(bus.cpu_done), 16'd0);
        end
        resetn = 1'b1;
        model_reset();
        for (int t = 1; t <= 4; t++) begin
            access(0, 8'(t), 0);
            chk("post_rst_miss", 16'(obs_hit), 16'd0);
        end
        access(0, 8'hEE, 0);
        chk("post_rst_ee_lat", 16'(obs_lat), 16'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
